// File: rtl/digit_sequence_checker_pkg.sv
// Shared constants and types for the digit sequence checker: the 7-5-1-4-2-3-0-2-6
// target sequence, special codes and the classification of accepted codes.
package digit_seq_pkg;

   localparam int         SEQ_LEN    = 9;
   localparam int         PROG_W     = 4;
   localparam logic [3:0] CODE_BLANK = 4'd15;
   localparam logic [3:0] CODE_FIRST = 4'd7;

   typedef logic [3:0]        code_t;
   typedef logic [PROG_W-1:0] prog_t;

   typedef enum logic [1:0] {
      EV_BLANK,
      EV_ADVANCE,
      EV_MATCH,
      EV_MISS
   } event_t;

   // Expected code at each sequence position; out-of-range positions never match a digit.
   function automatic code_t seq_code(input prog_t idx);
      case (idx)
         4'd0:    return 4'd7;
         4'd1:    return 4'd5;
         4'd2:    return 4'd1;
         4'd3:    return 4'd4;
         4'd4:    return 4'd2;
         4'd5:    return 4'd3;
         4'd6:    return 4'd0;
         4'd7:    return 4'd2;
         4'd8:    return 4'd6;
         default: return CODE_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/digit_sequence_checker_if.sv
// Bus between the digit sequencer side (master) and the sequence checker (slave).
interface digit_sequence_checker_if #(
   parameter int CNT_W = 8
);
   import digit_seq_pkg::*;

   code_t             digit_in;
   prog_t             progress;
   logic              match;
   logic              error;
   logic              blank;
   logic [CNT_W-1:0]  match_count;

   modport master (
      output digit_in,
      input  progress, match, error, blank, match_count
   );

   modport slave (
      input  digit_in,
      output progress, match, error, blank, match_count
   );

endinterface

// File: rtl/digit_sequence_checker_code_change_detect.sv
// Remembers the last accepted code and flags a new code whenever the bus value changes.
module code_change_detect
   import digit_seq_pkg::*;
(
   input  logic  clock,
   input  logic  reset,
   input  code_t digit_in,
   output logic  accept,
   output code_t code
);

   code_t last_code;

   assign accept = (digit_in != last_code);
   assign code   = digit_in;

   // Resetting to the blank code lets a digit held across reset be accepted right away.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_code <= CODE_BLANK;
      end else if (accept) begin
         last_code <= digit_in;
      end
   end

endmodule

// File: rtl/digit_sequence_checker.sv
// Recognises the 9-digit sequence on the sequencer code bus and reports progress/match/error/blank.
// Optional completed-sequence counter is built only when DIGIT_SEQ_CHECKER_COUNT_EN is defined.
module digit_sequence_checker
   import digit_seq_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   digit_sequence_checker_if.slave bus
);

   logic   accept;
   code_t  code;

   code_change_detect u_code_change_detect (
      .clock    (clock),
      .reset    (reset),
      .digit_in (bus.digit_in),
      .accept   (accept),
      .code     (code)
   );

   prog_t  progress_reg, progress_next;
   logic   match_reg, match_next;
   logic   error_reg, error_next;
   logic   blank_reg, blank_next;
   event_t ev;

   // One comparator per position; only the one selected by progress can fire.
   logic [SEQ_LEN-1:0] pos_hit;
   genvar gi;
   generate
      for (gi = 0; gi < SEQ_LEN; gi++) begin : g_pos
         assign pos_hit[gi] = (progress_reg == prog_t'(gi)) && (code == seq_code(prog_t'(gi)));
      end
   endgenerate

   always_comb begin
      ev = EV_MISS;
      if (code == CODE_BLANK) begin
         ev = EV_BLANK;
      end else if (pos_hit[SEQ_LEN-1]) begin
         ev = EV_MATCH;
      end else if (|pos_hit) begin
         ev = EV_ADVANCE;
      end
   end

   always_comb begin
      progress_next = progress_reg;
      blank_next    = blank_reg;
      match_next    = 1'b0;
      error_next    = 1'b0;
      if (accept) begin
         blank_next = 1'b0;
         case (ev)
            EV_BLANK: begin
               progress_next = '0;
               blank_next    = 1'b1;
            end
            EV_MATCH: begin
               progress_next = '0;
               match_next    = 1'b1;
            end
            EV_ADVANCE: begin
               progress_next = progress_reg + prog_t'(1);
            end
            default: begin
               // 7 only starts the sequence, so it is the only code that can restart mid-way.
               error_next    = (progress_reg != '0);
               progress_next = (code == CODE_FIRST) ? prog_t'(1) : prog_t'(0);
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         progress_reg <= '0;
         match_reg    <= 1'b0;
         error_reg    <= 1'b0;
         blank_reg    <= 1'b0;
      end else begin
         progress_reg <= progress_next;
         match_reg    <= match_next;
         error_reg    <= error_next;
         blank_reg    <= blank_next;
      end
   end

   assign bus.progress = progress_reg;
   assign bus.match    = match_reg;
   assign bus.error    = error_reg;
   assign bus.blank    = blank_reg;

`ifdef DIGIT_SEQ_CHECKER_COUNT_EN
   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (accept && (ev == EV_MATCH) && (count_reg != '1)) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign bus.match_count = count_reg;
`else
   localparam logic [CNT_W-1:0] COUNT_ZERO = '0;
   assign bus.match_count = COUNT_ZERO;
`endif

endmodule

// File: tb/tb_digit_sequence_checker.sv
// Directed bench for digit_sequence_checker (2-bit counter so saturation is reachable).
module tb_digit_sequence_checker;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   logic [3:0] seq [9] = '{4'd7, 4'd5, 4'd1, 4'd4, 4'd2, 4'd3, 4'd0, 4'd2, 4'd6};

   digit_sequence_checker_if #(.CNT_W(2)) bus ();

   digit_sequence_checker #(.CNT_W(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, exp);
      end
   endtask

   function automatic int cnt_exp(input int n);
`ifdef DIGIT_SEQ_CHECKER_COUNT_EN
      return (n > 3) ? 3 : n;
`else
      return 0;
`endif
   endfunction

   task automatic do_reset();
      @(negedge clock);
      bus.digit_in = 4'd15;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Present one code, check the edge that accepts it, then check it is not re-accepted while held.
   task automatic feed(input logic [3:0] c, input int p, input int m, input int e, input int b);
      @(negedge clock);
      bus.digit_in = c;
      @(posedge clock);
      #1;
      $display("code=%0d progress=%0d match=%0d error=%0d blank=%0d count=%0d",
               c, bus.progress, bus.match, bus.error, bus.blank, bus.match_count);
      chk($sformatf("progress@%0d", c), int'(bus.progress), p);
      chk($sformatf("match@%0d", c), int'(bus.match), m);
      chk($sformatf("error@%0d", c), int'(bus.error), e);
      chk($sformatf("blank@%0d", c), int'(bus.blank), b);
      repeat (2) begin
         @(posedge clock);
         #1;
         chk($sformatf("hold_match@%0d", c), int'(bus.match), 0);
         chk($sformatf("hold_error@%0d", c), int'(bus.error), 0);
         chk($sformatf("hold_progress@%0d", c), int'(bus.progress), p);
      end
   endtask

   task automatic full_loop(input int n_after);
      for (int i = 0; i < 9; i++) begin
         if (i == 8) feed(seq[i], 0, 1, 0, 0);
         else        feed(seq[i], i + 1, 0, 0, 0);
      end
      chk($sformatf("count_after_loop%0d", n_after), int'(bus.match_count), cnt_exp(n_after));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.digit_in = 4'd7;

      // 1: reset state, then a 7 held across reset release
      #1;
      chk("rst_progress", int'(bus.progress), 0);
      chk("rst_match", int'(bus.match), 0);
      chk("rst_error", int'(bus.error), 0);
      chk("rst_blank", int'(bus.blank), 0);
      chk("rst_count", int'(bus.match_count), 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         $display("held7 cycle=%0d progress=%0d", i, bus.progress);
         chk("held7_progress", int'(bus.progress), 1);
         chk("held7_match", int'(bus.match), 0);
         chk("held7_error", int'(bus.error), 0);
         chk("held7_blank", int'(bus.blank), 0);
      end

      // 2: complete the sequence from progress 1
      for (int i = 1; i < 9; i++) begin
         if (i == 8) feed(seq[i], 0, 1, 0, 0);
         else        feed(seq[i], i + 1, 0, 0, 0);
      end
      chk("count_single", int'(bus.match_count), cnt_exp(1));

      // 3: two back-to-back loops, then the trailing 7
      do_reset();
      full_loop(1);
      full_loop(2);
      feed(4'd7, 1, 0, 0, 0);
      chk("count_two_loops", int'(bus.match_count), cnt_exp(2));

      // 4: backward step, illegal codes, restart on 7, mismatch at the last position
      do_reset();
      feed(4'd7, 1, 0, 0, 0);
      feed(4'd5, 2, 0, 0, 0);
      feed(4'd1, 3, 0, 0, 0);
      feed(4'd5, 0, 0, 1, 0);
      feed(4'd7, 1, 0, 0, 0);
      feed(4'd9, 0, 0, 1, 0);
      feed(4'd8, 0, 0, 0, 0);
      feed(4'd7, 1, 0, 0, 0);
      feed(4'd5, 2, 0, 0, 0);
      feed(4'd7, 1, 0, 1, 0);
      for (int i = 1; i < 8; i++) feed(seq[i], i + 1, 0, 0, 0);
      feed(4'd3, 0, 0, 1, 0);

      // 6: counter saturation over five loops
      do_reset();
      for (int k = 1; k <= 5; k++) full_loop(k);

      // 5: blanking, then asynchronous reset mid-sequence
      feed(4'd7, 1, 0, 0, 0);
      feed(4'd5, 2, 0, 0, 0);
      feed(4'd15, 0, 0, 0, 1);
      feed(4'd7, 1, 0, 0, 0);
      feed(4'd5, 2, 0, 0, 0);
      feed(4'd1, 3, 0, 0, 0);
      feed(4'd4, 4, 0, 0, 0);
      chk("pre_reset_count", int'(bus.match_count), cnt_exp(5));
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      $display("async reset progress=%0d count=%0d", bus.progress, bus.match_count);
      chk("arst_progress", int'(bus.progress), 0);
      chk("arst_match", int'(bus.match), 0);
      chk("arst_error", int'(bus.error), 0);
      chk("arst_blank", int'(bus.blank), 0);
      chk("arst_count", int'(bus.match_count), 0);
      bus.digit_in = 4'd15;
      @(negedge clock);
      reset = 1'b0;
      feed(4'd7, 1, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
